// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encoding and buffer entry layout for uart_rx
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    typedef struct packed {
        logic       f_err;
        logic       p_err;
        logic [7:0] data;
    } rx_word_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick generator, restartable on a start edge
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int W   = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk)
        if (rst || restart) cnt <= '0;
        else                cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-data/parity/stop UART receiver with holding register, or a 4-entry
// FIFO when UART_RX_FIFO_EN is defined
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       p_sel,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       p_err,
    output logic       f_err,
    output logic       overrun
);
    state_t     state, state_n;
    logic       s1, rx_s, rx_d;
    logic       tick, restart, start_edge, mid, bit_end, done;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       par_bit, psel;
    logic       pop, push, full;
    rx_word_t   word;

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tick (
        .clk(clk), .rst(rst), .restart(restart), .tick(tick)
    );

    always_ff @(posedge clk)
        if (rst) {s1, rx_s, rx_d} <= 3'b111;
        else     {s1, rx_s, rx_d} <= {rx, s1, rx_s};

    assign start_edge = rx_d & ~rx_s;
    assign restart    = state == IDLE && start_edge;
    assign mid        = tick && tcnt == 4'(MID_TICK);
    assign bit_end    = tick && tcnt == 4'(OVERSAMPLE - 1);

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE:    state_n = start_edge ? START : IDLE;
            START:   state_n = mid ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_n = bit_end && bcnt == 3'(DATA_BITS - 1) ? PARITY : DATA;
            PARITY:  state_n = bit_end ? STOP : PARITY;
            STOP: begin
                state_n = bit_end ? IDLE : STOP;
                done    = bit_end;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // tcnt wraps 15->0 on its own, so DATA keeps a 16-tick cadence from mid-start
    always_ff @(posedge clk)
        if (rst) begin
            tcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            psel    <= 1'b0;
        end else begin
            tcnt <= state_n != state ? 4'd0 : tick ? tcnt + 4'd1 : tcnt;
            bcnt <= state == IDLE ? 3'd0 : state == DATA && bit_end ? bcnt + 3'd1 : bcnt;
            if (state == DATA && bit_end)   shreg   <= {rx_s, shreg[7:1]};
            if (state == PARITY && bit_end) par_bit <= rx_s;
            if (restart)                    psel    <= p_sel;
        end

    assign word = '{f_err: ~rx_s, p_err: ((^shreg) ^ par_bit) != ~psel, data: shreg};
    assign pop  = rd_en & valid;
    assign push = done & (~full | pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rx_word_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   rp, wp;
    logic [CW-1:0]   cnt;

    assign full  = cnt == CW'(FIFO_DEPTH);
    assign valid = cnt != '0;
    assign {f_err, p_err, data_out} = mem[rp];

    always_ff @(posedge clk)
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wp] <= word;
            wp  <= push ? wp + AW'(1) : wp;
            rp  <= pop ? rp + AW'(1) : rp;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
`else
    assign full = valid;

    always_ff @(posedge clk)
        if (rst) begin
            {f_err, p_err, data_out} <= '0;
            valid                    <= 1'b0;
        end else begin
            if (push) {f_err, p_err, data_out} <= word;
            valid <= push | (valid & ~pop);
        end
`endif

    always_ff @(posedge clk)
        if (rst)                      overrun <= 1'b0;
        else if (done & full & ~pop)  overrun <= 1'b1;
        else if (rd_en)               overrun <= 1'b0;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a queue-based receive model, plus directed
// frames with literal expectations. Honours UART_RX_FIFO_EN for buffer depth.
module tb_uart_rx;
    localparam int CF   = 768_100;
    localparam int BD   = 9600;
    localparam int DIV  = CF / (BD * 16);
    localparam int BITC = DIV * 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 0, rst = 1, rx = 1, p_sel = 0, rd_en = 0;
    logic [7:0] data_out;
    logic       valid, p_err, f_err, overrun;

    int         total = 0, bad = 0;
    logic [9:0] q[$];
    logic       movr = 0, unsure = 1, exp_ps = 0;

    uart_rx #(.CLK_FREQ(CF), .BAUD(BD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .p_sel(p_sel), .rd_en(rd_en),
        .data_out(data_out), .valid(valid), .p_err(p_err), .f_err(f_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: got no end after 90000 cycles, want finish");
        $fatal(1);
    end

    always @(negedge clk)
        if (!unsure && !rst) begin
            total++;
            if (valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL cyc_valid: got %b want %b", valid, q.size() != 0);
            end
            total++;
            if (overrun !== movr) begin
                bad++;
                $display("FAIL cyc_overrun: got %b want %b", overrun, movr);
            end
            if (q.size() != 0) begin
                total++;
                if ({f_err, p_err, data_out} !== q[0]) begin
                    bad++;
                    $display("FAIL cyc_head: got %h want %h", {f_err, p_err, data_out}, q[0]);
                end
            end
        end

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1;
        cyc(nbits * BITC);
    endtask

    task automatic rd();
        rd_en = 1;
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        movr = 0;
        #1 rd_en = 0;
    endtask

    task automatic frame(input logic [7:0] d, input logic ps, input logic pbit,
                         input logic stp, input int abort_bit);
        logic perr;
        p_sel  = ps;
        exp_ps = ps;
        rx = 0;
        cyc(BITC / 2);
        p_sel = 1'($urandom);
        cyc(BITC - BITC / 2);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                cyc(BITC / 2);
                rst = 1;
                unsure = 1;
                q.delete();
                movr = 0;
                cyc(3);
                rst = 0;
                rx = 1;
                cyc(2 * BITC);
                unsure = 0;
                return;
            end
            cyc(BITC);
        end
        rx = pbit;
        cyc(BITC);
        rx = stp;
        cyc(20);
        unsure = 1;
        cyc(50);
        perr = ((^d) ^ pbit) != !exp_ps;
        if (q.size() < DEPTH) q.push_back({!stp, perr, d});
        else movr = 1;
        unsure = 0;
        cyc(BITC - 70);
        rx = 1;
    endtask

    initial begin
        cyc(5);
        rst = 0;
        unsure = 0;
        @(negedge clk);
        chk("rst_valid", 10'(valid), 0);
        chk("rst_data", 10'(data_out), 0);
        chk("rst_flags", 10'({p_err, f_err, overrun}), 0);
        cyc(1);
        idle(1);

        frame(8'hFF, 1, 0, 1, -1);
        idle(1);
        chk("ff_model", q[0], {2'b00, 8'hFF});
        chk("ff_out", {f_err, p_err, data_out}, {2'b00, 8'hFF});
        chk("ff_valid", 10'(valid), 1);
        rd();
        @(negedge clk);
        chk("ff_popped", 10'(valid), 0);
        cyc(1);

        frame(8'hA5, 0, 0, 1, -1);
        idle(1);
        chk("a5_model", q[0], {2'b01, 8'hA5});
        chk("a5_perr", {f_err, p_err, data_out}, {2'b01, 8'hA5});
        rd();
        frame(8'hA5, 0, 1, 1, -1);
        idle(1);
        chk("a5_ok", {f_err, p_err, data_out}, {2'b00, 8'hA5});
        rd();

        frame(8'h3C, 1, 0, 0, -1);
        idle(1);
        chk("3c_ferr", {f_err, p_err, data_out}, {2'b10, 8'h3C});
        rd();
        frame(8'h11, 1, 0, 1, -1);
        idle(1);
        chk("11_after_ferr", {f_err, p_err, data_out}, {2'b00, 8'h11});
        rd();

        rx = 0;
        cyc(3 * DIV);
        idle(2);
        @(negedge clk);
        chk("glitch_valid", 10'(valid), 0);
        cyc(1);

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) frame(8'(i * 8'h11), 1, 0, 1, -1);
        idle(1);
        chk("fifo_ovr_set", 10'(overrun), 1);
        chk("fifo_head0", 10'(data_out), 10'h11);
        rd();
        @(negedge clk);
        chk("fifo_ovr_clr", 10'(overrun), 0);
        for (int i = 2; i <= 4; i++) begin
            chk("fifo_head", 10'(data_out), 10'(i * 8'h11));
            cyc(1);
            rd();
            @(negedge clk);
        end
        chk("fifo_empty", 10'(valid), 0);
        cyc(1);
`else
        frame(8'h11, 1, 0, 1, -1);
        frame(8'h22, 1, 0, 1, -1);
        idle(1);
        chk("hold_keep", 10'(data_out), 10'h11);
        chk("hold_ovr_set", 10'(overrun), 1);
        rd();
        @(negedge clk);
        chk("hold_ovr_clr", 10'(overrun), 0);
        chk("hold_dropped", 10'(valid), 0);
        cyc(1);
`endif

        frame(8'h5A, 1, 0, 1, 4);
        @(negedge clk);
        chk("rst_mid_valid", 10'({valid, overrun}), 0);
        cyc(1);
        frame(8'h81, 1, 0, 1, -1);
        idle(1);
        chk("81_after_rst", {f_err, p_err, data_out}, {2'b00, 8'h81});
        chk("81_only", 10'(q.size()), 1);
        rd();

        for (int n = 0; n < 30; n++) begin
            logic stp;
            stp = $urandom_range(0, 5) != 0;
            frame(8'($urandom), 1'($urandom), 1'($urandom), stp, -1);
            idle(stp ? $urandom_range(0, 2) : $urandom_range(1, 2));
            for (int r = $urandom_range(0, 2); r > 0; r--) rd();
        end
        while (q.size() != 0) rd();
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
